fp_div_sequencer: RTL

FP_DIV_SEQUENCER -- requirements
Module: fp_div_sequencer

---
 rtl/fp_div_pkg.sv | 19 +
 rtl/fp_div_classify.sv | 16 +
 rtl/fp_div_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fp_div_pkg.sv
// Shared types and constants for the FP divide sequencer.
package fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FAST = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int FLAG_UF = 0;
    localparam int FLAG_DZ = 1;
    localparam int FLAG_TO = 2;

    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam logic [7:0] EXP_INF = 8'hFF;

endpackage

// File: rtl/fp_div_classify.sv
// Operand classification: zero/denormal exponent detection and quotient sign.
module fp_div_classify
    import fp_div_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        x_zero,
    output logic        y_zero,
    output logic        sign
);

    assign x_zero = (x[EXP_MSB:EXP_LSB] == '0);
    assign y_zero = (y[EXP_MSB:EXP_LSB] == '0);
    assign sign   = x[31] ^ y[31];

endmodule

// File: rtl/fp_div_sequencer.sv
// Request/result sequencer around an external iterative FP divider,
// with zero-exponent fast path and a RUN-cycle timeout.
module fp_div_sequencer
    import fp_div_pkg::*;
#(
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_z,
    output logic [2:0]  res_flags,
    output logic        div_run,
    output logic [31:0] div_x,
    output logic [31:0] div_y,
    input  logic        div_stall,
    input  logic [31:0] div_z,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [31:0]   opx, opy, opx_d, opy_d;
    logic [31:0]   z, z_d;
    logic [2:0]    flags, flags_d;
    logic [31:0]   cls_x, cls_y;
    logic          x_zero, y_zero, sign;

    // In IDLE classify the incoming request; afterwards the latched operands.
    assign cls_x = (state == IDLE) ? req_x : opx;
    assign cls_y = (state == IDLE) ? req_y : opy;

    fp_div_classify u_cls (
        .x      (cls_x),
        .y      (cls_y),
        .x_zero (x_zero),
        .y_zero (y_zero),
        .sign   (sign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            opx   <= '0;
            opy   <= '0;
            z     <= '0;
            flags <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            opx   <= opx_d;
            opy   <= opy_d;
            z     <= z_d;
            flags <= flags_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        opx_d   = opx;
        opy_d   = opy;
        z_d     = z;
        flags_d = flags;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    opx_d   = req_x;
                    opy_d   = req_y;
                    cnt_d   = '0;
                    state_d = (x_zero || y_zero) ? FAST : RUN;
                end
            end
            FAST: begin
                state_d = DONE;
                flags_d = '0;
                if (x_zero) begin
                    z_d = '0;
                end else begin
                    z_d              = {sign, EXP_INF, 23'b0};
                    flags_d[FLAG_DZ] = 1'b1;
                end
            end
            RUN: begin
                if (!div_stall) begin
                    z_d              = div_z;
                    flags_d          = '0;
                    flags_d[FLAG_UF] = (div_z == '0);
                    state_d          = DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    z_d              = '0;
                    flags_d          = '0;
                    flags_d[FLAG_TO] = 1'b1;
                    state_d          = DONE;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            DONE: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign res_valid = (state == DONE);
    assign div_run   = (state == RUN);
    assign busy      = (state != IDLE);
    assign div_x     = opx;
    assign div_y     = opy;
    assign res_z     = z;
    assign res_flags = flags;

endmodule
